// File: rtl/flash_rdseq_pkg.sv
`default_nettype none
// ============================================================================
// Module : flash_pkg
// Brief  : Shared command codes, format encodings and FSM states for the
//          SPI flash read sequencer.
// Rev    : 1.0
// ============================================================================
package flash_pkg;

    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_STATUS    = 8'h05;

    localparam logic [2:0] FMT_IDLE = 3'b000;
    localparam logic [2:0] FMT_SDR  = 3'b001;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CMD   = 4'd1,
        ST_ADDR  = 4'd2,
        ST_DUMMY = 4'd3,
        ST_DATA  = 4'd4,
        ST_CAPT  = 4'd5,
        ST_HOLD  = 4'd6,
        ST_CSOFF = 4'd7,
        ST_FIN   = 4'd8
    } state_e;

endpackage
`default_nettype wire

// File: rtl/flash_rdseq_if.sv
`default_nettype none
// ============================================================================
// Module : flash_rdseq_if
// Brief  : Byte-level SPI flash port (strobe/ready with CS# format control).
// Rev    : 1.0
// ============================================================================
interface flash_rdseq_if;

    logic       f_ready;
    logic       f_wr;
    logic [7:0] f_din;
    logic [2:0] f_format;
    logic [3:0] f_prescale;
    logic [7:0] f_dout;

    modport master (
        input  f_ready,
        input  f_dout,
        output f_wr,
        output f_din,
        output f_format,
        output f_prescale
    );

    modport slave (
        output f_ready,
        output f_dout,
        input  f_wr,
        input  f_din,
        input  f_format,
        input  f_prescale
    );

endinterface
`default_nettype wire

// File: rtl/flash_rdseq.sv
`default_nettype none
// ============================================================================
// Module : flash_rdseq
// Brief  : Turns one request into a fast-read (0x0B) stream or a read-status
//          (0x05) byte sequence on the byte-level SPI flash port.
// Rev    : 1.0
// ============================================================================
module flash_rdseq
    import flash_pkg::*;
#(
    parameter logic [2:0]  FMT_ACTIVE  = FMT_SDR,
    parameter logic [3:0]  PRESCALE    = 4'd0,
    parameter int unsigned DUMMY_BYTES = 1
) (
    input  wire logic        clk,
    input  wire logic        arstn,
    input  wire logic        start,
    input  wire logic        op,
    input  wire logic [23:0] addr,
    input  wire logic [15:0] count,
    output logic             busy,
    output logic             done,
    output logic [7:0]       status,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  wire logic        o_ready,
    flash_rdseq_if.master    fl
);

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  o_data_q, o_data_d;
    logic        o_valid_q, o_valid_d;
    logic        f_wr_q, f_wr_d;
    logic [7:0]  f_din_q, f_din_d;
    logic [2:0]  f_format_q, f_format_d;
    logic        op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [1:0]  dummy_cnt_q, dummy_cnt_d;

    // A byte slot exists when the port is ready and no strobe was issued last
    // cycle; the same guard hides the stale ready seen right after a strobe.
    logic slot;
    logic room;
    assign slot = fl.f_ready & ~f_wr_q;
    assign room = ~o_valid_q | o_ready;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        status_d    = status_q;
        o_data_d    = o_data_q;
        o_valid_d   = o_valid_q & ~o_ready;
        f_wr_d      = 1'b0;
        f_din_d     = f_din_q;
        f_format_d  = f_format_q;
        op_d        = op_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        byte_idx_d  = byte_idx_q;
        dummy_cnt_d = dummy_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d      = 1'b1;
                    op_d        = op;
                    addr_d      = addr;
                    remaining_d = count;
                    byte_idx_d  = 2'd0;
                    dummy_cnt_d = 2'd0;
                    state_d     = (count == 16'd0 && !op) ? ST_FIN : ST_CMD;
                end
            end
            ST_CMD: begin
                if (slot) begin
                    f_wr_d     = 1'b1;
                    f_din_d    = op_q ? CMD_STATUS : CMD_FAST_READ;
                    f_format_d = FMT_ACTIVE;
                    state_d    = op_q ? ST_DATA : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (slot) begin
                    f_wr_d = 1'b1;
                    case (byte_idx_q)
                        2'd0:    f_din_d = addr_q[23:16];
                        2'd1:    f_din_d = addr_q[15:8];
                        default: f_din_d = addr_q[7:0];
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd2) begin
                        state_d = (DUMMY_BYTES == 0) ? ST_DATA : ST_DUMMY;
                    end
                end
            end
            ST_DUMMY: begin
                if (slot) begin
                    f_wr_d      = 1'b1;
                    f_din_d     = 8'h00;
                    dummy_cnt_d = dummy_cnt_q + 2'd1;
                    if (dummy_cnt_q == 2'(DUMMY_BYTES - 1)) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Fast-read only clocks a new byte in once the holding register frees up.
                if (slot && (op_q || room)) begin
                    f_wr_d  = 1'b1;
                    f_din_d = 8'h00;
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                if (slot) begin
                    if (op_q) begin
                        status_d = fl.f_dout;
                        state_d  = ST_CSOFF;
                    end else begin
                        o_data_d    = fl.f_dout;
                        o_valid_d   = 1'b1;
                        remaining_d = remaining_q - 16'd1;
                        state_d     = (remaining_q == 16'd1) ? ST_CSOFF : ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (room) begin
                    state_d = ST_DATA;
                end
            end
            ST_CSOFF: begin
                if (slot) begin
                    f_wr_d     = 1'b1;
                    f_din_d    = 8'h00;
                    f_format_d = FMT_IDLE;
                    state_d    = ST_FIN;
                end
            end
            ST_FIN: begin
                if (slot) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= 8'h00;
            o_data_q    <= 8'h00;
            o_valid_q   <= 1'b0;
            f_wr_q      <= 1'b0;
            f_din_q     <= 8'h00;
            f_format_q  <= FMT_IDLE;
            op_q        <= 1'b0;
            addr_q      <= 24'h0;
            remaining_q <= 16'h0;
            byte_idx_q  <= 2'd0;
            dummy_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            status_q    <= status_d;
            o_data_q    <= o_data_d;
            o_valid_q   <= o_valid_d;
            f_wr_q      <= f_wr_d;
            f_din_q     <= f_din_d;
            f_format_q  <= f_format_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            byte_idx_q  <= byte_idx_d;
            dummy_cnt_q <= dummy_cnt_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign status        = status_q;
    assign o_data        = o_data_q;
    assign o_valid       = o_valid_q;
    assign fl.f_wr       = f_wr_q;
    assign fl.f_din      = f_din_q;
    assign fl.f_format   = f_format_q;
    assign fl.f_prescale = PRESCALE;

endmodule
`default_nettype wire

// File: tb/tb_flash_rdseq.sv
`default_nettype none
// ============================================================================
// Module : tb_flash_rdseq
// Brief  : Self-checking bench for flash_rdseq with a behavioural flash port.
// Rev    : 1.0
// ============================================================================
module tb_flash_rdseq;
    import flash_pkg::*;

    localparam int DUMMY = 1;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [15:0] count = 16'h0;
    logic        busy, done, o_valid;
    logic [7:0]  status, o_data;
    logic        o_ready = 1'b1;

    flash_rdseq_if fif();

    flash_rdseq #(
        .FMT_ACTIVE (FMT_SDR),
        .PRESCALE   (4'd0),
        .DUMMY_BYTES(DUMMY)
    ) dut (
        .clk    (clk),
        .arstn  (arstn),
        .start  (start),
        .op     (op),
        .addr   (addr),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .status (status),
        .o_data (o_data),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .fl     (fif.master)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural flash port ----------------
    int          fl_nb  = 0;
    int          fl_lat = 0;
    logic [7:0]  fl_cmd = 8'h00;
    logic [23:0] fl_a   = 24'h0;
    logic [7:0]  fl_resp = 8'h00;

    function automatic logic [7:0] img(input logic [23:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    initial begin
        fif.f_ready = 1'b1;
        fif.f_dout  = 8'h00;
    end

    always @(posedge clk) begin
        if (fif.f_wr) begin
            if (fif.f_format == FMT_IDLE) begin
                fl_nb   <= 0;
                fl_resp <= 8'h00;
            end else begin
                case (fl_nb)
                    0: fl_cmd <= fif.f_din;
                    1: fl_a[23:16] <= fif.f_din;
                    2: fl_a[15:8]  <= fif.f_din;
                    3: fl_a[7:0]   <= fif.f_din;
                    default: ;
                endcase
                if (fl_cmd == CMD_STATUS && fl_nb >= 1)
                    fl_resp <= 8'h00;
                else if (fl_cmd == CMD_FAST_READ && fl_nb >= 4 + DUMMY)
                    fl_resp <= img(fl_a + 24'(fl_nb - 4 - DUMMY));
                else
                    fl_resp <= 8'hEE;
                fl_nb <= fl_nb + 1;
            end
            fif.f_ready <= 1'b0;
            fl_lat      <= LAT;
        end else if (fl_lat > 0) begin
            fl_lat <= fl_lat - 1;
            if (fl_lat == 1) begin
                fif.f_ready <= 1'b1;
                fif.f_dout  <= fl_resp;
            end
        end else if (fif.f_format == FMT_IDLE) begin
            fl_nb <= 0;
        end
    end

    // ---------------- scoreboard and protocol monitor ----------------
    int   vectors = 0;
    int   errs    = 0;
    logic [10:0] din_q[$];
    logic [7:0]  data_q[$];
    bit   chk_en = 1'b1;
    int   wr_cnt = 0, done_cnt = 0, busy_cnt = 0;
    bit   valid_seen = 1'b0;
    logic prev_wr = 1'b0;
    logic [2:0] prev_fmt = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        vectors++;
        errs++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    always @(negedge clk) begin
        if (arstn) begin
            if (fif.f_wr) begin
                wr_cnt++;
                check("wr_needs_ready", {31'd0, fif.f_ready}, 32'd1);
                check("wr_not_b2b", {31'd0, prev_wr}, 32'd0);
                if (chk_en) begin
                    if (din_q.size() == 0) flag("din_unexpected", {21'd0, fif.f_format, fif.f_din});
                    else check("din_seq", {21'd0, fif.f_format, fif.f_din}, {21'd0, din_q.pop_front()});
                end
            end else if (fif.f_format !== prev_fmt) begin
                flag("fmt_changed_without_wr", {29'd0, fif.f_format});
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (o_valid) valid_seen = 1'b1;
            if (o_valid && o_ready && chk_en) begin
                if (data_q.size() == 0) flag("data_unexpected", {24'd0, o_data});
                else check("data_seq", {24'd0, o_data}, {24'd0, data_q.pop_front()});
            end
        end
        prev_wr  = fif.f_wr;
        prev_fmt = fif.f_format;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input bit o, input logic [23:0] a, input logic [15:0] c);
        if (!o && c == 16'd0) return;
        if (o) begin
            din_q.push_back({FMT_SDR, CMD_STATUS});
            din_q.push_back({FMT_SDR, 8'h00});
        end else begin
            din_q.push_back({FMT_SDR, CMD_FAST_READ});
            din_q.push_back({FMT_SDR, a[23:16]});
            din_q.push_back({FMT_SDR, a[15:8]});
            din_q.push_back({FMT_SDR, a[7:0]});
            for (int i = 0; i < DUMMY; i++) din_q.push_back({FMT_SDR, 8'h00});
            for (int i = 0; i < int'(c); i++) begin
                din_q.push_back({FMT_SDR, 8'h00});
                data_q.push_back(img(a + 24'(i)));
            end
        end
        din_q.push_back({FMT_IDLE, 8'h00});
    endtask

    task automatic clear_counts();
        wr_cnt = 0; done_cnt = 0; busy_cnt = 0; valid_seen = 1'b0;
    endtask

    task automatic issue(input bit o, input logic [23:0] a, input logic [15:0] c);
        start = 1'b1; op = o; addr = a; count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt == 0 && t < 3000) begin
            tick();
            t++;
        end
        check({name, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
        repeat (5) tick();
    endtask

    typedef struct {
        bit          op;
        logic [23:0] addr;
        logic [15:0] count;
        bit          stall;
        logic [7:0]  exp_status;
        int          exp_wr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{op: 1'b0, addr: 24'h000010, count: 16'd3, stall: 1'b0, exp_status: 8'h00, exp_wr: 9};
        tbl[1] = '{op: 1'b0, addr: 24'h000010, count: 16'd5, stall: 1'b1, exp_status: 8'h00, exp_wr: 11};
        tbl[2] = '{op: 1'b0, addr: 24'h000000, count: 16'd0, stall: 1'b0, exp_status: 8'h00, exp_wr: 0};
        tbl[3] = '{op: 1'b1, addr: 24'h000000, count: 16'd1, stall: 1'b0, exp_status: 8'h00, exp_wr: 3};
        tbl[4] = '{op: 1'b0, addr: 24'h0001F0, count: 16'd2, stall: 1'b0, exp_status: 8'h00, exp_wr: 8};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     {31'd0, busy},          32'd0);
        check("rst_done",     {31'd0, done},          32'd0);
        check("rst_status",   {24'd0, status},        32'd0);
        check("rst_o_data",   {24'd0, o_data},        32'd0);
        check("rst_o_valid",  {31'd0, o_valid},       32'd0);
        check("rst_f_wr",     {31'd0, fif.f_wr},      32'd0);
        check("rst_f_din",    {24'd0, fif.f_din},     32'd0);
        check("rst_f_format", {29'd0, fif.f_format},  32'd0);
        check("rst_prescale", {28'd0, fif.f_prescale}, 32'd0);
        arstn = 1'b1;
        repeat (4) tick();

        for (int v = 0; v < 5; v++) begin
            clear_counts();
            push_expect(tbl[v].op, tbl[v].addr, tbl[v].count);
            o_ready = tbl[v].stall ? 1'b0 : 1'b1;
            issue(tbl[v].op, tbl[v].addr, tbl[v].count);
            if (tbl[v].stall) begin
                int t = 0;
                int base;
                while (!o_valid && t < 1000) begin tick(); t++; end
                check("stall_first_byte", {31'd0, o_valid}, 32'd1);
                base = wr_cnt;
                repeat (20) tick();
                check("stall_no_wr", wr_cnt - base, 32'd0);
                o_ready = 1'b1;
            end
            wait_done("vec");
            check("vec_done_once", done_cnt,        32'd1);
            check("vec_wr_count",  wr_cnt,          tbl[v].exp_wr);
            check("vec_din_drain", din_q.size(),    32'd0);
            check("vec_data_drain", data_q.size(),  32'd0);
            if (tbl[v].op) begin
                check("vec_status",   {24'd0, status},      {24'd0, tbl[v].exp_status});
                check("vec_no_valid", {31'd0, valid_seen},  32'd0);
            end
            if (!tbl[v].op && tbl[v].count == 16'd0)
                check("vec_busy_cycles", busy_cnt, 32'd1);
        end

        // count=0 fast-read: exact busy/done timing
        clear_counts();
        issue(1'b0, 24'h000040, 16'd0);
        check("c0_busy_t1", {31'd0, busy}, 32'd1);
        check("c0_done_t1", {31'd0, done}, 32'd0);
        tick();
        check("c0_busy_t2", {31'd0, busy}, 32'd0);
        check("c0_done_t2", {31'd0, done}, 32'd1);
        tick();
        check("c0_done_t3", {31'd0, done}, 32'd0);
        repeat (4) tick();

        // start during a read is ignored
        clear_counts();
        push_expect(1'b0, 24'h000010, 16'd3);
        issue(1'b0, 24'h000010, 16'd3);
        repeat (6) tick();
        issue(1'b1, 24'h000200, 16'd9);
        repeat (12) tick();
        issue(1'b0, 24'h000300, 16'd4);
        wait_done("midstart");
        check("midstart_done_once", done_cnt,       32'd1);
        check("midstart_din_drain", din_q.size(),   32'd0);
        check("midstart_data_drain", data_q.size(), 32'd0);

        // reset during the data phase
        chk_en = 1'b0;
        clear_counts();
        issue(1'b0, 24'h000010, 16'd4);
        begin
            int t = 0;
            while (!o_valid && t < 1000) begin tick(); t++; end
            check("rst_mid_reached_data", {31'd0, o_valid}, 32'd1);
        end
        tick();
        arstn = 1'b0;
        #1;
        check("rst_mid_f_wr",     {31'd0, fif.f_wr},     32'd0);
        check("rst_mid_f_format", {29'd0, fif.f_format}, 32'd0);
        check("rst_mid_busy",     {31'd0, busy},         32'd0);
        check("rst_mid_o_valid",  {31'd0, o_valid},      32'd0);
        repeat (2) tick();
        arstn = 1'b1;
        din_q.delete();
        data_q.delete();
        repeat (10) tick();
        chk_en = 1'b1;

        clear_counts();
        push_expect(1'b0, 24'h000100, 16'd2);
        check("post_rst_first_exp", {24'd0, data_q[0]}, 32'h5A);
        issue(1'b0, 24'h000100, 16'd2);
        wait_done("post_rst");
        check("post_rst_done_once", done_cnt,       32'd1);
        check("post_rst_din_drain", din_q.size(),   32'd0);
        check("post_rst_data_drain", data_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
